// File: rtl/rr_mux_select_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin mux select arbiter.
// Holds the FSM state type, a clog2 helper and the modulo-N pointer step.
package mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned inc_mod(input int unsigned v,
                                            input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_mux_select_arbiter_if.sv
// Request/grant bundle between requesters, consumer and the arbiter.
// The slave side is the arbiter; the master side drives req/done.
interface rr_mux_select_arbiter_if #(
    parameter int N = 8,
    parameter int M = 3
);
    logic [N-1:0] req;
    logic         done;
    logic [M-1:0] sel;
    logic         grant_valid;
    logic [N-1:0] grant_onehot;
    logic         timeout;

    modport master (
        output req, done,
        input  sel, grant_valid, grant_onehot, timeout
    );

    modport slave (
        input  req, done,
        output sel, grant_valid, grant_onehot, timeout
    );
endinterface

// File: rtl/rr_mux_select_arbiter_pick.sv
// Rotating-priority first-one search over a doubled request vector.
// The window [ptr, ptr+N) of {req,req} makes the wrap modulo N.
module rr_priority_pick #(
    parameter int N = 8,
    parameter int M = 3
) (
    input  logic [N-1:0] req,
    input  logic [M-1:0] ptr,
    output logic [M-1:0] pick,
    output logic         any
);
    logic [2*N-1:0] dbl;

    // Scan downward so the lowest in-window set bit wins last.
    always_comb begin
        dbl  = {req, req};
        pick = '0;
        any  = 1'b0;
        for (int i = 2*N-1; i >= 0; i--) begin
            if (dbl[i] && i >= int'(ptr) && i < int'(ptr) + N) begin
                any  = 1'b1;
                pick = (i >= N) ? M'(i - N) : M'(i);
            end
        end
    end
endmodule

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin grant FSM producing a registered N:1 mux select code.
// Grants lock until done or hold timeout, then re-pick with no bubble.
module rr_mux_select_arbiter
    import mux_pkg::*;
#(
    parameter int N       = 8,
    parameter int M       = 3,
    parameter int TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rst,
    rr_mux_select_arbiter_if.slave bus
);
    localparam int CW = clog2(TIMEOUT + 1) < 1 ? 1 : clog2(TIMEOUT + 1);

    state_t         state_q, state_d;
    logic [M-1:0]   sel_q, sel_d;
    logic [M-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   oh_q, oh_d;
    logic           tmo_q, tmo_d;
    logic [M-1:0]   nxt_ptr, pick_ptr, pick;
    logic           any, expire;

    assign nxt_ptr  = M'(inc_mod(32'(sel_q), N));
    assign pick_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;
    assign expire   = (cnt_q == CW'(TIMEOUT - 1));

    rr_priority_pick #(.N(N), .M(M)) u_pick (
        .req  (bus.req),
        .ptr  (pick_ptr),
        .pick (pick),
        .any  (any)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            oh_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            oh_q    <= oh_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next state: grant on any request, release on done or expiry.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = GRANT;
                    sel_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (bus.done || expire) begin
                    ptr_d = nxt_ptr;
                    tmo_d = !bus.done;
                    cnt_d = '0;
                    if (any) begin
                        sel_d = pick;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        oh_d = (state_d == GRANT) ? (N'(1) << sel_d) : '0;
    end

    // Outputs come straight from registers.
    always_comb begin
        bus.sel          = sel_q;
        bus.grant_valid  = (state_q == GRANT);
        bus.grant_onehot = oh_q;
        bus.timeout      = tmo_q;
    end
endmodule

// File: tb/tb_rr_mux_select_arbiter.sv
// Scoreboard bench: N=8 and N=5 arbiters against a rotating-priority model.
// Driver pushes expectations at negedge; monitor compares after posedge.
module tb_rr_mux_select_arbiter;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rr_mux_select_arbiter_if #(.N(8), .M(3)) b8 ();
    rr_mux_select_arbiter_if #(.N(5), .M(3)) b5 ();

    rr_mux_select_arbiter #(.N(8), .M(3), .TIMEOUT(TO)) u8 (
        .clk(clk), .rst(rst), .bus(b8.slave)
    );
    rr_mux_select_arbiter #(.N(5), .M(3), .TIMEOUT(TO)) u5 (
        .clk(clk), .rst(rst), .bus(b5.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        bit gv;
        int oh;
        bit tmo;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_of[2] = '{8, 5};
    int m_ptr[2];
    int m_sel[2];
    int m_cnt[2];
    bit m_gv[2];

    int passed = 0;
    int total  = 0;

    function automatic void chk(input string name, input int act,
                                input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d required %0d", name, act, req);
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_sel[d] = 0; m_cnt[d] = 0; m_gv[d] = 0;
        end
    endfunction

    // First requester at or after p, wrapping modulo n; -1 if none.
    function automatic int first_req(input int n, input int r, input int p);
        for (int k = 0; k < n; k++) begin
            int idx;
            idx = (p + k) % n;
            if (((r >> idx) & 1) != 0) return idx;
        end
        return -1;
    endfunction

    function automatic exp_t step(input int d, input int r, input bit dn);
        exp_t e;
        int n, f;
        n = n_of[d];
        e.tmo = 1'b0;
        if (!m_gv[d]) begin
            f = first_req(n, r, m_ptr[d]);
            if (f >= 0) begin
                m_gv[d] = 1; m_sel[d] = f; m_cnt[d] = 0;
            end
        end else if (dn || m_cnt[d] == TO - 1) begin
            e.tmo = !dn;
            m_ptr[d] = (m_sel[d] + 1) % n;
            m_cnt[d] = 0;
            f = first_req(n, r, m_ptr[d]);
            if (f >= 0) m_sel[d] = f;
            else m_gv[d] = 0;
        end else begin
            m_cnt[d]++;
        end
        e.sel = m_sel[d];
        e.gv  = m_gv[d];
        e.oh  = m_gv[d] ? (1 << m_sel[d]) : 0;
        return e;
    endfunction

    task automatic cyc(input int r8, input bit d8, input int r5, input bit d5);
        @(negedge clk);
        b8.req  = 8'(r8);
        b8.done = d8;
        b5.req  = 5'(r5);
        b5.done = d5;
        if (!rst) begin
            q0.push_back(step(0, r8 & 8'hFF, d8));
            q1.push_back(step(1, r5 & 5'h1F, d5));
        end
        @(posedge clk);
    endtask

    // Monitor: pop expectations and compare registered outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("sel8", int'(b8.sel), e.sel);
            chk("gv8", int'(b8.grant_valid), int'(e.gv));
            chk("oh8", int'(b8.grant_onehot), e.oh);
            chk("tmo8", int'(b8.timeout), int'(e.tmo));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            chk("sel5", int'(b5.sel), e.sel);
            chk("gv5", int'(b5.grant_valid), int'(e.gv));
            chk("oh5", int'(b5.grant_onehot), e.oh);
            chk("tmo5", int'(b5.timeout), int'(e.tmo));
            chk("sel5_range", int'(b5.sel < 3'd5), 1);
        end
    end

    initial begin
        int hit;
        b8.req = 8'hFF; b8.done = 1'b0;
        b5.req = 5'h1F; b5.done = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel8", int'(b8.sel), 0);
        chk("rst_gv8", int'(b8.grant_valid), 0);
        chk("rst_oh8", int'(b8.grant_onehot), 0);
        chk("rst_gv5", int'(b5.grant_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        cyc(8'hFF, 0, 5'h1F, 0);
        #1 chk("first_sel8", int'(b8.sel), 0);
        repeat (9) cyc(8'hFF, 1, 5'h1F, 1);
        cyc(8'h00, 1, 8'h00, 1);

        cyc(8'h04, 0, 5'h10, 0);
        #1 chk("n5_first", int'(b5.sel), 4);
        cyc(8'h84, 1, 5'h10, 1);
        #1 chk("ptr3_sel7", int'(b8.sel), 7);
        chk("n5_wrap", int'(b5.sel), 4);
        cyc(8'h84, 1, 5'h00, 1);
        #1 chk("wrap_sel2", int'(b8.sel), 2);
        cyc(8'h00, 1, 5'h00, 0);
        #1 chk("idle_gv8", int'(b8.grant_valid), 0);
        chk("idle_keep_sel", int'(b8.sel), 2);

        cyc(8'h01, 0, 5'h00, 0);
        hit = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc(8'h01, 0, 5'h00, 0);
            #1;
            if (b8.timeout) begin
                hit = k;
                break;
            end
        end
        chk("timeout_cycles", hit, TO);
        chk("timeout_regrant", int'(b8.sel), 0);
        chk("timeout_gv", int'(b8.grant_valid), 1);
        cyc(8'h00, 1, 5'h00, 0);

        cyc(8'h40, 0, 5'h00, 0);
        #1 chk("pre_rst_sel6", int'(b8.sel), 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_sel", int'(b8.sel), 0);
        chk("arst_gv", int'(b8.grant_valid), 0);
        chk("arst_oh", int'(b8.grant_onehot), 0);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(8'h40, 0, 5'h00, 0);
        #1 chk("post_rst_sel6", int'(b8.sel), 6);

        for (int i = 0; i < 600; i++) begin
            int r8, r5;
            r8 = (i % 3 == 0) ? int'($urandom & $urandom & 8'hFF)
                              : int'($urandom & 8'hFF);
            r5 = int'($urandom & $urandom & 5'h1F);
            cyc(r8, ($urandom % 6) == 0, r5, ($urandom % 5) == 0);
        end

        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
